i2s_mix_sched: RTL and testbench
================================

# i2s_mix_sched

Per-frame sample scheduler and mixer for the I2S output path. On each sample-rate `load` strobe from the I2S serializer it polls up to `NUM_SRC` voice sources in fixed order and acknowledges each pending sample. It sums the acknowledged stereo samples and presents the mixed pair on `l_data`/`r_data` at the next `load`. It is the single owner of the serializer's sample inputs, so voice generators never drive it directly.

## Interface

Parameters:
- `NUM_SRC`, default 4: number of sources, legal range 1..8.
- `DW`, default 24: sample width, signed two's complement.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  system reset; asynchronous, active-low.
- `load`  in  1  one-cycle sample-rate strobe from the serializer.
- `src_req`  in  NUM_SRC  source i has a sample pending.
- `src_l`  in  NUM_SRC*DW  left samples, packed; source i at [i*DW +: DW].
- `src_r`  in  NUM_SRC*DW  right samples, same packing.
- `src_ack`  out  NUM_SRC  one-cycle pulse: source i's sample consumed.
- `mute`  in  1  force the mixed result to zero.
- `clr_ovr`  in  1  clears `overrun`.
- `l_data`  out  DW  signed left sample to the serializer.
- `r_data`  out  DW  signed right sample to the serializer.
- `frame_busy`  out  1  high while the FSM is not IDLE.
- `active_cnt`  out  4  number of sources mixed in the last committed frame.
- `overrun`  out  1  sticky: `load` arrived while busy.

## Operation

- FSM states: IDLE, SCAN, COMMIT.
- IDLE, `load`=1:
  - `l_data`/`r_data` <= staged pair.
  - `active_cnt` <= staged count.
  - Left/right accumulators and the count are cleared; idx <= 0; go to SCAN.
- SCAN, one cycle per source:
  - If `src_req[idx]` is high: pulse `src_ack[idx]`, add the sign-extended `src_l`/`src_r` slices into the (DW+3)-bit accumulators, and increment the count.
  - idx increments each cycle. After idx = NUM_SRC-1, go to COMMIT.
- COMMIT:
  - Reduce the accumulators to DW bits (see Configuration).
  - If `mute` is sampled high this cycle, the staged pair is 0. The count still reflects the sources acknowledged.
  - Go to IDLE.
- `src_req[i]` is sampled only in its own SCAN cycle. A request raised or dropped at any other time has no effect for that frame.
- At most one `src_ack` bit is high in any cycle. No ack is issued outside SCAN.
- `load` in SCAN or COMMIT:
  - Sets `overrun`.
  - Otherwise ignored: no output update and no restart. The scan in progress completes normally.
- `clr_ovr` clears `overrun`. If `clr_ovr` and an overrunning `load` coincide, the set wins.
- Reset (asynchronous, mid-operation included):
  - FSM returns to IDLE.
  - `src_ack`, `l_data`, `r_data`, staged pair, accumulators, `active_cnt`, `overrun` and `frame_busy` all go to 0.

## Timing

- `load` at cycle T (FSM in IDLE):
  - SCAN occupies cycles T+1 .. T+NUM_SRC.
  - `src_ack[i]` is high in cycle T+1+i.
  - COMMIT is in cycle T+NUM_SRC+1; the FSM is back in IDLE at T+NUM_SRC+2.
- `frame_busy` is high for exactly NUM_SRC+1 cycles per frame.
- Latency: samples acknowledged in frame k appear on `l_data`/`r_data` after the clock edge that samples `load` k+1. Outputs change only on that edge.
- Minimum legal `load` spacing is NUM_SRC+2 cycles; normal operation has far more.

## Configuration

- `MIX_SAT_EN` defined:
  - COMMIT clamps each channel to [-2^(DW-1), 2^(DW-1)-1].
  - DW=24: positive overflow gives 0x7FFFFF; negative overflow gives 0x800000.
- `MIX_SAT_EN` undefined:
  - COMMIT takes the low DW bits of the accumulator (two's-complement wrap).
  - No clamp logic is built.

## Test plan

- Reset: hold `reset`=0 while `load`/`src_req` toggle → all outputs 0, no `src_ack`; FSM in IDLE after release.
- Basic mix: NUM_SRC=4, `src_req`=4'b0011, src0 L=0x100000, src1 L=0x0F0000, R=0 → `src_ack` pulses at T+1 and T+2, `frame_busy` high 5 cycles; after the next `load`, `l_data`=0x1F0000, `r_data`=0, `active_cnt`=2.
- Overflow: all 4 sources L=0x7FFFFF, R=0x800000 → with `MIX_SAT_EN`, `l_data`=0x7FFFFF and `r_data`=0x800000; without it, `l_data`=0xFFFFFC and `r_data`=0x000000.
- Mute: `mute`=1, 3 sources requesting → 3 acks issued; after the next `load`, `l_data`=`r_data`=0 and `active_cnt`=3.
- Overrun: second `load` 2 cycles after the first → `overrun`=1, outputs unchanged, scan completes with 4 SCAN cycles; `clr_ovr` pulse → `overrun`=0.
- Reset mid-scan: assert `reset` at T+2 → `src_ack` drops immediately, no further acks; the next `load` after release starts a clean frame.

Source files
------------

// File: rtl/i2s_mix_sched.sv
// Per-frame voice scheduler/mixer feeding the I2S serializer's sample inputs.
// Optional feature: define MIX_SAT_EN to clamp the mixed sum instead of wrapping it.
module i2s_mix_sched #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DW      = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [NUM_SRC-1:0]    src_req,
  input  logic [NUM_SRC*DW-1:0] src_l,
  input  logic [NUM_SRC*DW-1:0] src_r,
  output logic [NUM_SRC-1:0]    src_ack,
  input  logic                  mute,
  input  logic                  clr_ovr,
  output logic [DW-1:0]         l_data,
  output logic [DW-1:0]         r_data,
  output logic                  frame_busy,
  output logic [3:0]            active_cnt,
  output logic                  overrun
);

  localparam int unsigned IdxW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned AccW = DW + 3;

  typedef enum logic [1:0] {StIdle, StScan, StCommit} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [AccW-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DW-1:0]     stg_l_q, stg_l_d, stg_r_q, stg_r_d;
  logic [3:0]        stg_cnt_q, stg_cnt_d;
  logic [DW-1:0]     l_q, l_d, r_q, r_d;
  logic [3:0]        act_q, act_d;
  logic              ovr_q, ovr_d;
  logic [DW-1:0]     sel_l, sel_r;

  function automatic logic [DW-1:0] reduce(input logic [AccW-1:0] a);
`ifdef MIX_SAT_EN
    // In range only when the guard bits all match the result's sign bit.
    if ((a[AccW-1:DW-1] == '0) || (a[AccW-1:DW-1] == '1)) begin
      return a[DW-1:0];
    end else if (a[AccW-1]) begin
      return {1'b1, {(DW-1){1'b0}}};
    end else begin
      return {1'b0, {(DW-1){1'b1}}};
    end
`else
    return a[DW-1:0];
`endif
  endfunction

  assign sel_l = src_l[idx_q*DW +: DW];
  assign sel_r = src_r[idx_q*DW +: DW];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    cnt_d     = cnt_q;
    stg_l_d   = stg_l_q;
    stg_r_d   = stg_r_q;
    stg_cnt_d = stg_cnt_q;
    l_d       = l_q;
    r_d       = r_q;
    act_d     = act_q;
    ovr_d     = ovr_q;
    src_ack   = '0;

    if (clr_ovr) ovr_d = 1'b0;
    if (load && (state_q != StIdle)) ovr_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (load) begin
          l_d     = stg_l_q;
          r_d     = stg_r_q;
          act_d   = stg_cnt_q;
          acc_l_d = '0;
          acc_r_d = '0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (src_req[idx_q]) begin
          src_ack[idx_q] = 1'b1;
          acc_l_d = acc_l_q + {{3{sel_l[DW-1]}}, sel_l};
          acc_r_d = acc_r_q + {{3{sel_r[DW-1]}}, sel_r};
          cnt_d   = cnt_q + 4'd1;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == IdxW'(NUM_SRC - 1)) state_d = StCommit;
      end
      StCommit: begin
        stg_l_d   = mute ? '0 : reduce(acc_l_q);
        stg_r_d   = mute ? '0 : reduce(acc_r_q);
        stg_cnt_d = cnt_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      cnt_q     <= '0;
      stg_l_q   <= '0;
      stg_r_q   <= '0;
      stg_cnt_q <= '0;
      l_q       <= '0;
      r_q       <= '0;
      act_q     <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      cnt_q     <= cnt_d;
      stg_l_q   <= stg_l_d;
      stg_r_q   <= stg_r_d;
      stg_cnt_q <= stg_cnt_d;
      l_q       <= l_d;
      r_q       <= r_d;
      act_q     <= act_d;
      ovr_q     <= ovr_d;
    end
  end

  assign l_data     = l_q;
  assign r_data     = r_q;
  assign active_cnt = act_q;
  assign overrun    = ovr_q;
  assign frame_busy = (state_q != StIdle);

endmodule

// File: tb/tb_i2s_mix_sched.sv
// Bench for i2s_mix_sched: vector table of frames, scoreboard of staged results popped at next load.
module tb_i2s_mix_sched;
  localparam int NS = 4;
  localparam int DW = 24;

  logic              clk = 1'b0;
  logic              reset, load, mute, clr_ovr;
  logic [NS-1:0]     src_req, src_ack;
  logic [NS*DW-1:0]  src_l, src_r;
  logic [DW-1:0]     l_data, r_data;
  logic              frame_busy, overrun;
  logic [3:0]        active_cnt;

  i2s_mix_sched #(.NUM_SRC(NS), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .src_req    (src_req),
    .src_l      (src_l),
    .src_r      (src_r),
    .src_ack    (src_ack),
    .mute       (mute),
    .clr_ovr    (clr_ovr),
    .l_data     (l_data),
    .r_data     (r_data),
    .frame_busy (frame_busy),
    .active_cnt (active_cnt),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NS-1:0]    req;
    logic [NS*DW-1:0] l;
    logic [NS*DW-1:0] r;
    logic             mute;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [3:0]    cnt;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input vec_t v);
    exp_t          e;
    longint        sl = 0;
    longint        sr = 0;
    logic [DW-1:0] x;
    for (int i = 0; i < NS; i++) begin
      if (v.req[i]) begin
        x  = v.l[i*DW +: DW];
        sl = sl + longint'($signed(x));
        x  = v.r[i*DW +: DW];
        sr = sr + longint'($signed(x));
      end
    end
    if (v.mute) begin
      sl = 0;
      sr = 0;
    end
`ifdef MIX_SAT_EN
    if (sl > 64'sd8388607) sl = 64'sd8388607;
    if (sl < -64'sd8388608) sl = -64'sd8388608;
    if (sr > 64'sd8388607) sr = 64'sd8388607;
    if (sr < -64'sd8388608) sr = -64'sd8388608;
`endif
    e.l   = sl[DW-1:0];
    e.r   = sr[DW-1:0];
    e.cnt = 4'($countones(v.req));
    return e;
  endfunction

  // One frame: load, check prior result, check each scan/commit cycle, push new expectation.
  task automatic frame(input vec_t v, input int ovr_at, input logic clr_with);
    logic [NS-1:0] ea;
    @(negedge clk);
    chk("idle_busy", 32'(frame_busy), 32'd0);
    load = 1'b1; src_req = v.req; src_l = v.l; src_r = v.r; mute = v.mute;
    @(posedge clk); #1 load = 1'b0;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      cur = sb.pop_front();
      chk("l_data", 32'(l_data), 32'(cur.l));
      chk("r_data", 32'(r_data), 32'(cur.r));
      chk("active_cnt", 32'(active_cnt), 32'(cur.cnt));
    end
    for (int i = 0; i < NS; i++) begin
      @(negedge clk);
      ea = v.req[i] ? (NS'(1) << i) : '0;
      chk("scan_ack", 32'(src_ack), 32'(ea));
      chk("scan_busy", 32'(frame_busy), 32'd1);
      if (i == ovr_at) begin
        load = 1'b1;
        clr_ovr = clr_with;
      end
      @(posedge clk); #1 load = 1'b0; clr_ovr = 1'b0;
    end
    @(negedge clk);
    chk("commit_ack", 32'(src_ack), 32'd0);
    chk("commit_busy", 32'(frame_busy), 32'd1);
    chk("hold_l", 32'(l_data), 32'(cur.l));
    @(negedge clk);
    chk("done_busy", 32'(frame_busy), 32'd0);
    sb.push_back(model(v));
  endtask

  initial begin
    vecs[0] = '{req: 4'b0011, l: {24'h0, 24'h0, 24'h0F0000, 24'h100000}, r: '0, mute: 1'b0};
    vecs[1] = '{req: 4'b1111, l: {4{24'h7FFFFF}}, r: {4{24'h800000}}, mute: 1'b0};
    vecs[2] = '{req: 4'b0111, l: {24'h5, 24'h3, 24'h2, 24'h1}, r: {24'h5, 24'h3, 24'h2, 24'h1},
                mute: 1'b1};
    vecs[3] = '{req: 4'b1010, l: {24'hFFFFF0, 24'h777777, 24'h000010, 24'h777777},
                r: {24'h000001, 24'h0, 24'h123456, 24'h0}, mute: 1'b0};
    vecs[4] = '{req: 4'b0000, l: {4{24'h111111}}, r: {4{24'h222222}}, mute: 1'b0};
    vecs[5] = '{req: 4'b1111, l: {4{24'hC00000}}, r: {24'h4, 24'h3, 24'h2, 24'h1}, mute: 1'b0};

    reset = 1'b0; load = 1'b0; mute = 1'b0; clr_ovr = 1'b0;
    src_req = '0; src_l = '0; src_r = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_ack", 32'(src_ack), 32'd0);
      chk("rst_out", 32'({l_data, r_data} == '0), 32'd1);
      chk("rst_flags", 32'({frame_busy, overrun, active_cnt}), 32'd0);
      load = ~load; src_req = ~src_req;
    end
    @(negedge clk);
    load = 1'b0; src_req = '0; reset = 1'b1;
    sb.push_back('0);

    for (int k = 0; k < 6; k++) begin
      frame(vecs[k], -1, 1'b0);
      chk("no_overrun", 32'(overrun), 32'd0);
    end

    // Second load two cycles after the first, coinciding with clr_ovr.
    frame(vecs[0], 1, 1'b1);
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("ovr_hold_r", 32'(r_data), 32'(cur.r));
    @(negedge clk); clr_ovr = 1'b1;
    @(posedge clk); #1 clr_ovr = 1'b0;
    chk("overrun_clr", 32'(overrun), 32'd0);

    // Reset in cycle T+2 of a scan.
    frame(vecs[1], -1, 1'b0);
    @(negedge clk);
    load = 1'b1; src_req = '1;
    @(posedge clk); #1 load = 1'b0;
    @(negedge clk);
    chk("pre_rst_ack", 32'(src_ack), 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    #1;
    chk("midrst_ack", 32'(src_ack), 32'd0);
    chk("midrst_busy", 32'(frame_busy), 32'd0);
    chk("midrst_out", 32'({l_data, r_data} == '0), 32'd1);
    chk("midrst_cnt", 32'(active_cnt), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_hold_ack", 32'(src_ack), 32'd0);
      load = ~load;
    end
    @(negedge clk);
    load = 1'b0; reset = 1'b1;
    sb.delete();
    sb.push_back('0);
    frame(vecs[3], -1, 1'b0);
    frame(vecs[4], -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
